// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared types and helpers for the stack access sequencer
// Purpose: command opcodes, sequencer FSM states, controller window codes and
//          the word-index to byte-address helper.
// Ports:   none (package)
package stack_pkg;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_PEEK = 2'b10,
        OP_DROP = 2'b11
    } stack_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } seq_state_e;

    localparam logic [1:0] WIN_BYTE = 2'b00;
    localparam logic [1:0] WIN_HALF = 2'b01;
    localparam logic [1:0] WIN_WORD = 2'b10;

    // Controller is byte addressed; the sequencer only ever does aligned words.
    function automatic logic [7:0] word_to_byte_addr(input logic [5:0] word_idx);
        return {word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/stack_ptr_calc.sv
// rtl/stack_ptr_calc.sv - combinational stack pointer / target index / guard decode
// Purpose: for the presented opcode, compute the stack pointer after the
//          command, the word index the command touches and whether the
//          command must be rejected (STACK_GUARD_EN builds only).
// Ports:   sp       - current stack pointer (0..DEPTH)
//          op       - command opcode
//          offset   - PEEK offset from top
//          sp_next  - stack pointer once the command completes
//          word_idx - memory word index accessed by the command
//          reject   - command refused by the guard (always 0 without the guard)
module stack_ptr_calc import stack_pkg::*; #(
    parameter int DEPTH = 64
) (
    input  logic [6:0] sp,
    input  stack_op_e  op,
    input  logic [5:0] offset,
    output logic [6:0] sp_next,
    output logic [5:0] word_idx,
    output logic       reject
);

    localparam logic [6:0] DEPTH_V = 7'(DEPTH);

    logic [6:0] sp_m1;
    logic [6:0] sp_inc;
    logic [6:0] sp_dec;
    logic [6:0] peek_pos;

    // Raw 7-bit arithmetic gives the address; sp itself wraps inside 0..DEPTH.
    assign sp_m1    = sp - 7'd1;
    assign sp_inc   = (sp == DEPTH_V) ? 7'd0 : sp + 7'd1;
    assign sp_dec   = (sp == 7'd0) ? DEPTH_V - 7'd1 : sp_m1;
    assign peek_pos = sp_m1 - {1'b0, offset};

    always_comb begin
        sp_next  = sp;
        word_idx = 6'd0;
        reject   = 1'b0;
        case (op)
            OP_PUSH: begin
                sp_next  = sp_inc;
                word_idx = sp[5:0];
            end
            OP_POP: begin
                sp_next  = sp_dec;
                word_idx = sp_m1[5:0];
            end
            OP_PEEK: begin
                sp_next  = sp;
                word_idx = peek_pos[5:0];
            end
            OP_DROP: begin
                sp_next  = sp_dec;
                word_idx = 6'd0;
            end
            default: ;
        endcase
`ifdef STACK_GUARD_EN
        case (op)
            OP_PUSH: reject = (sp == DEPTH_V);
            OP_POP:  reject = (sp == 7'd0);
            OP_DROP: reject = (sp == 7'd0);
            OP_PEEK: reject = ({1'b0, offset} >= sp);
            default: reject = 1'b0;
        endcase
`endif
    end

endmodule

// File: rtl/stack_access_sequencer.sv
// rtl/stack_access_sequencer.sv - PUSH/POP/PEEK/DROP sequencer for the stack memory controller
// Purpose: accepts one word-level stack command at a time, drives the stack
//          controller (registered read data, delayed write with forwarding),
//          owns the stack pointer and returns data/status.
// Ports:   clk, rst_n (sync, active-low)
//          cmd_valid/cmd_ready/cmd_op/cmd_data/cmd_offset - command channel
//          rsp_valid/rsp_ready/rsp_data/rsp_err          - response channel
//          depth/empty/full                              - stack occupancy
//          mem_addr/mem_wdata/mem_we/mem_window/mem_rdata - controller side
//          guard_fault - sticky reject flag, present only with STACK_GUARD_EN
// Config:  define STACK_GUARD_EN for overflow/underflow/range rejection.
module stack_access_sequencer import stack_pkg::*; #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [5:0]        cmd_offset,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [6:0]        depth,
    output logic              empty,
    output logic              full,
    output logic [7:0]        mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [1:0]        mem_window,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef STACK_GUARD_EN
    ,
    output logic              guard_fault
`endif
);

    seq_state_e state;
    logic [6:0] sp;
    logic [6:0] sp_pend;
    logic       op_push_q;

    logic [6:0] calc_sp_next;
    logic [5:0] calc_idx;
    logic       calc_reject;
    stack_op_e  op_in;

    assign op_in = stack_op_e'(cmd_op);

    stack_ptr_calc #(.DEPTH(DEPTH)) u_calc (
        .sp       (sp),
        .op       (op_in),
        .offset   (cmd_offset),
        .sp_next  (calc_sp_next),
        .word_idx (calc_idx),
        .reject   (calc_reject)
    );

    assign depth      = sp;
    assign empty      = (sp == 7'd0);
    assign full       = (sp == 7'(DEPTH));
    assign mem_window = WIN_WORD;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sp        <= 7'd0;
            sp_pend   <= 7'd0;
            op_push_q <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 8'd0;
            mem_wdata <= '0;
`ifdef STACK_GUARD_EN
            guard_fault <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b0;
                        op_push_q <= (op_in == OP_PUSH);
                        // sp moves at the end of ISSUE so the address uses the old value
                        sp_pend   <= calc_sp_next;
                        if (calc_reject) begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
`ifdef STACK_GUARD_EN
                            guard_fault <= 1'b1;
`endif
                        end else if (op_in == OP_DROP) begin
                            sp        <= calc_sp_next;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            mem_addr <= word_to_byte_addr(calc_idx);
                            mem_we   <= (op_in == OP_PUSH);
                            if (op_in == OP_PUSH) begin
                                mem_wdata <= cmd_data;
                            end
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    mem_we <= 1'b0;
                    sp     <= sp_pend;
                    if (op_push_q) begin
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // controller read data is registered: valid one cycle after address
                    rsp_data  <= mem_rdata;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_access_sequencer.sv
// tb/tb_stack_access_sequencer.sv - scoreboard bench for stack_access_sequencer
// Purpose: directed commands with hand-computed responses; expected responses
//          are queued at issue and a forked monitor pops/compares them on each
//          response handshake. A small controller model supplies mem_rdata.
// Ports:   none (top-level bench)
module tb_stack_access_sequencer;
    import stack_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic [5:0]  cmd_offset;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [6:0]  depth;
    logic        empty;
    logic        full;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [1:0]  mem_window;
    logic [31:0] mem_rdata;
`ifdef STACK_GUARD_EN
    logic        guard_fault;
`endif

    int n_cmp = 0;
    int n_mis = 0;
    int we_cnt = 0;
    logic [7:0] we_addr = 8'd0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    stack_access_sequencer #(.DEPTH(64), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_offset (cmd_offset),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .depth      (depth),
        .empty      (empty),
        .full       (full),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_window (mem_window),
        .mem_rdata  (mem_rdata)
`ifdef STACK_GUARD_EN
        ,
        .guard_fault(guard_fault)
`endif
    );

    // Controller model: write lands one edge late, reads are registered and
    // forward a write still pending to the same word.
    logic [31:0] mem [64];
    logic        wr_pend = 1'b0;
    logic [5:0]  wr_idx = 6'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] rd_q = 32'd0;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    end

    always @(posedge clk) begin
        if (wr_pend) mem[wr_idx] <= wr_data;
        wr_pend <= mem_we;
        wr_idx  <= mem_addr[7:2];
        wr_data <= mem_wdata;
        rd_q    <= (wr_pend && wr_idx == mem_addr[7:2]) ? wr_data : mem[mem_addr[7:2]];
    end
    assign mem_rdata = rd_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one command from #1 after a posedge; returns #1 after the response handshake edge.
    task automatic do_cmd(input logic [1:0] op, input logic [31:0] data, input logic [5:0] off,
                          input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                          input int hold);
        int t;
        int lat;
        logic ok;
        t = 0;
        while (!cmd_ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 20) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        rsp_ready  = (hold == 0);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_data   = data;
        cmd_offset = off;
        exp_q.push_back({exp_e, exp_d});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        if (hold > 0) begin
            ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (!(rsp_valid && rsp_data == exp_d && !cmd_ready)) ok = 1'b0;
            end
            chk("hold_stable", 32'(ok), 32'd1);
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        logic [32:0] e;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_data = 32'd0;
        cmd_offset = 6'd0;
        rsp_ready = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (mem_we) begin
                    we_cnt++;
                    we_addr = mem_addr;
                end
                if (rst_n && rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_data", rsp_data, e[31:0]);
                        chk("rsp_err", 32'(rsp_err), 32'(e[32]));
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("mem_window", 32'(mem_window), 32'd2);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single PUSH
        w0 = we_cnt;
        do_cmd(OP_PUSH, 32'hDEADBEEF, 6'd0, 32'd0, 1'b0, 2, 0);
        chk("push_we_pulses", 32'(we_cnt - w0), 32'd1);
        chk("push_we_addr", 32'(we_addr), 32'h00);
        chk("push_depth", 32'(depth), 32'd1);

        // DROP back to empty, then push/push/pop/pop
        do_cmd(OP_DROP, 32'd0, 6'd0, 32'd0, 1'b0, 1, 0);
        chk("drop_empty", 32'(empty), 32'd1);
        do_cmd(OP_PUSH, 32'h11, 6'd0, 32'd0, 1'b0, 2, 0);
        do_cmd(OP_PUSH, 32'h22, 6'd0, 32'd0, 1'b0, 2, 0);
        w0 = we_cnt;
        do_cmd(OP_POP, 32'd0, 6'd0, 32'h22, 1'b0, 3, 0);
        chk("pop_no_write", 32'(we_cnt - w0), 32'd0);
        chk("pop_depth", 32'(depth), 32'd1);
        do_cmd(OP_POP, 32'd0, 6'd0, 32'h11, 1'b0, 3, 0);
        chk("pop2_empty", 32'(empty), 32'd1);

        // PEEK into the stack
        do_cmd(OP_PUSH, 32'hA, 6'd0, 32'd0, 1'b0, 2, 0);
        do_cmd(OP_PUSH, 32'hB, 6'd0, 32'd0, 1'b0, 2, 0);
        do_cmd(OP_PUSH, 32'hC, 6'd0, 32'd0, 1'b0, 2, 0);
        do_cmd(OP_PEEK, 32'd0, 6'd2, 32'hA, 1'b0, 3, 0);
        chk("peek2_addr", 32'(mem_addr), 32'h00);
        chk("peek_depth", 32'(depth), 32'd3);
        do_cmd(OP_PEEK, 32'd0, 6'd0, 32'hC, 1'b0, 3, 0);
        chk("peek0_addr", 32'(mem_addr), 32'h08);

        // Back-pressure: response held for 5 cycles
        do_cmd(OP_PEEK, 32'd0, 6'd1, 32'hB, 1'b0, 3, 5);
        do_cmd(OP_DROP, 32'd0, 6'd0, 32'd0, 1'b0, 1, 0);
        do_cmd(OP_DROP, 32'd0, 6'd0, 32'd0, 1'b0, 1, 0);
        do_cmd(OP_DROP, 32'd0, 6'd0, 32'd0, 1'b0, 1, 0);
        chk("drain_depth", 32'(depth), 32'd0);

`ifdef STACK_GUARD_EN
        w0 = we_cnt;
        do_cmd(OP_POP, 32'd0, 6'd0, 32'd0, 1'b1, 1, 0);
        chk("guard_pop_no_mem", 32'(we_cnt - w0), 32'd0);
        chk("guard_fault_set", 32'(guard_fault), 32'd1);
        chk("guard_pop_depth", 32'(depth), 32'd0);
`endif
        // Fill to capacity
        for (int i = 0; i < 64; i++)
            do_cmd(OP_PUSH, 32'h100 + 32'(i), 6'd0, 32'd0, 1'b0, 2, 0);
        chk("fill_depth", 32'(depth), 32'd64);
        chk("fill_full", 32'(full), 32'd1);
`ifdef STACK_GUARD_EN
        w0 = we_cnt;
        do_cmd(OP_PUSH, 32'hFFFF, 6'd0, 32'd0, 1'b1, 1, 0);
        chk("guard_push_no_mem", 32'(we_cnt - w0), 32'd0);
        chk("guard_push_depth", 32'(depth), 32'd64);
        do_cmd(OP_PEEK, 32'd0, 6'd63, 32'h100, 1'b0, 3, 0);
        chk("guard_peek_addr", 32'(mem_addr), 32'h00);
`else
        do_cmd(OP_PUSH, 32'hFFFF, 6'd0, 32'd0, 1'b0, 2, 0);
        chk("wrap_push_addr", 32'(we_addr), 32'h00);
        chk("wrap_push_depth", 32'(depth), 32'd0);
        do_cmd(OP_POP, 32'd0, 6'd0, 32'h13F, 1'b0, 3, 0);
        chk("wrap_pop_depth", 32'(depth), 32'd63);
`endif

        // Reset while a POP sits in WAIT
        chk("pre_abort_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op = OP_POP;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_depth", 32'(depth), 32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef STACK_GUARD_EN
        chk("abort_guard_clear", 32'(guard_fault), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_cmd(OP_PUSH, 32'h5A5A, 6'd0, 32'd0, 1'b0, 2, 0);
        do_cmd(OP_POP, 32'd0, 6'd0, 32'h5A5A, 1'b0, 3, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
